// File: rtl/alu_axi_sequencer.sv
// AXI-lite master that runs one complete ALU operation. It writes op1, op2 and
// opcode, reads back the result register, and returns the data and response status.
module alu_axi_sequencer #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_op1,
  input  logic [DATA_WIDTH-1:0] cmd_op2,
  input  logic [DATA_WIDTH-1:0] cmd_opcode,
  // result port
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err,
  output logic [1:0]            res_resp,
  output logic [CNT_WIDTH-1:0]  done_count,
  // AXI-lite write channels
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // AXI-lite read channels
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // current FSM state, for observation only
  output logic [2:0]            dbg_state
);

  // Handshake rule for every port: a transfer occurs on a rising clk edge where
  // valid and ready are both high. Valids are registered, never depend on the
  // matching ready, and stay high until their own transfer completes.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESULT  = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RES_ADDR = BASE_ADDR + ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [DATA_WIDTH-1:0] opc_q, opc_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;
  logic [1:0]            res_resp_q, res_resp_d;
  logic [CNT_WIDTH-1:0]  done_q, done_d;
  logic                  aw_fin, w_fin;

  function automatic logic [DATA_WIDTH-1:0] wr_word(
    input logic [1:0]            idx,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c
  );
    logic [DATA_WIDTH-1:0] w;
    case (idx)
      2'd0:    w = a;
      2'd1:    w = b;
      default: w = c;
    endcase
    return w;
  endfunction

  // A channel is finished once its valid has dropped or is being accepted now.
  assign aw_fin = !awvalid_q || awready;
  assign w_fin  = !wvalid_q  || wready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opc_d      = opc_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    res_resp_d = res_resp_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op1_d      = cmd_op1;
          op2_d      = cmd_op2;
          opc_d      = cmd_opcode;
          idx_d      = 2'd0;
          res_err_d  = 1'b0;
          res_resp_d = 2'b00;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = BASE_ADDR;
          wdata_d    = cmd_op1;
          state_d    = WR;
        end
      end

      WR: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_fin && w_fin)      state_d   = WR_RESP;
      end

      WR_RESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) begin
            // Abort the rest of the sequence; the error is the result.
            res_err_d  = 1'b1;
            res_resp_d = bresp;
            res_data_d = '0;
            state_d    = RESULT;
          end else if (idx_q < 2'd2) begin
            idx_d     = idx_q + 2'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = BASE_ADDR + ADDR_WIDTH'(idx_q + 2'd1);
            wdata_d   = wr_word(idx_q + 2'd1, op1_q, op2_q, opc_q);
            state_d   = WR;
          end else begin
            araddr_d = RES_ADDR;
            state_d  = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end

      RD_DATA: begin
        if (rvalid) begin
          res_data_d = rdata;
          if (rresp != 2'b00) begin
            res_err_d  = 1'b1;
            res_resp_d = rresp;
          end
          state_d = RESULT;
        end
      end

      RESULT: begin
        if (res_ready) begin
          done_d  = done_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      op1_q      <= '0;
      op2_q      <= '0;
      opc_q      <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      res_resp_q <= 2'b00;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      opc_q      <= opc_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      res_resp_q <= res_resp_d;
      done_q     <= done_d;
    end
  end

  // State-decoded strobes come straight from the state register, so they are glitch-free.
  assign cmd_ready  = (state_q == IDLE);
  assign bready     = (state_q == WR_RESP);
  assign arvalid    = (state_q == RD_ADDR);
  assign rready     = (state_q == RD_DATA);
  assign res_valid  = (state_q == RESULT);

  assign awvalid    = awvalid_q;
  assign wvalid     = wvalid_q;
  assign awaddr     = awaddr_q;
  assign wdata      = wdata_q;
  assign araddr     = araddr_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign res_resp   = res_resp_q;
  assign done_count = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_axi_sequencer.sv
// Directed bench for alu_axi_sequencer. A vector table feeds a reactive AXI-lite
// slave model; hand sequences cover reset mid-read and back-to-back commands.
`timescale 1ns/1ps
module tb_alu_axi_sequencer;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int CW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_op1, cmd_op2, cmd_opcode;
  logic          res_valid, res_ready, res_err;
  logic [DW-1:0] res_data;
  logic [1:0]    res_resp;
  logic [CW-1:0] done_count;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic [2:0]    dbg_state;

  // second instance at BASE_ADDR 0x40 shares every input, so it runs in lockstep
  logic          cmd_ready_b, res_valid_b, res_err_b;
  logic [DW-1:0] res_data_b, wdata_b;
  logic [1:0]    res_resp_b;
  logic [CW-1:0] done_count_b;
  logic [AW-1:0] awaddr_b, araddr_b;
  logic          awvalid_b, wvalid_b, bready_b, arvalid_b, rready_b;
  logic [2:0]    dbg_state_b;

  alu_axi_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .cmd_opcode(cmd_opcode), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_resp(res_resp), .done_count(done_count),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready), .dbg_state(dbg_state)
  );

  alu_axi_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(32'h40), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .cmd_opcode(cmd_opcode), .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
    .res_err(res_err_b), .res_resp(res_resp_b), .done_count(done_count_b),
    .awaddr(awaddr_b), .awvalid(awvalid_b), .awready(awready), .wdata(wdata_b), .wvalid(wvalid_b),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready_b),
    .araddr(araddr_b), .arvalid(arvalid_b), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready_b), .dbg_state(dbg_state_b)
  );

  // slave knobs and observed traffic
  int            aw_delay, w_delay, berr_idx, wr_cnt, viol;
  logic [1:0]    berr_val, rr_val;
  logic [DW-1:0] rd_val;
  bit            r_stall;
  logic [AW-1:0] aw_log[$], ar_log[$], aw1_log[$], ar1_log[$];
  logic [DW-1:0] w_log[$];

  int n_vec = 0;
  int n_mis = 0;

  // Slave model: updates at negedge, so its decisions hold across the next posedge.
  int aw_wait, w_wait;
  bit aw_got, w_got, b_acc, ar_got, r_acc, aw_pend, w_pend;
  always @(negedge clk) begin
    if (!rstn) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      bresp = 2'b00; rresp = 2'b00; rdata = '0;
      aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_acc = 0;
      ar_got = 0; r_acc = 0; aw_pend = 0; w_pend = 0;
    end else begin
      if (bready && !bvalid && !(aw_got && w_got)) viol++;
      if ((aw_pend && !awvalid) || (w_pend && !wvalid)) viol++;
      if (bvalid) begin
        if (b_acc) begin bvalid = 1'b0; bresp = 2'b00; b_acc = 0; wr_cnt++; end
      end else if (aw_got && w_got) begin
        bvalid = 1'b1;
        bresp  = (wr_cnt == berr_idx) ? berr_val : 2'b00;
        aw_got = 0; w_got = 0;
      end
      if (rvalid) begin
        if (r_acc) begin rvalid = 1'b0; rresp = 2'b00; r_acc = 0; end
      end else if (ar_got && !r_stall) begin
        rvalid = 1'b1; rdata = rd_val; rresp = rr_val; ar_got = 0;
      end
      if (awvalid) begin awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= w_delay); w_wait++; end
      else begin wready = 1'b0; w_wait = 0; end
      arready = arvalid;
      if (awvalid && awready) begin aw_got = 1; aw_log.push_back(awaddr); end
      if (awvalid_b && awready) aw1_log.push_back(awaddr_b);
      if (wvalid && wready) begin w_got = 1; w_log.push_back(wdata); end
      if (arvalid && arready) begin ar_got = 1; ar_log.push_back(araddr); end
      if (arvalid_b && arready) ar1_log.push_back(araddr_b);
      aw_pend = awvalid && !awready;
      w_pend  = wvalid && !wready;
      b_acc   = bvalid && bready;
      r_acc   = rvalid && rready;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] op1, op2, opc, rd;
    logic [1:0]    rr;
    int            berr_idx;
    logic [1:0]    bv;
    int            awd, wd, hold;
    bit            pulse;
    int            exp_nwr;
    bit            exp_rd;
    logic [DW-1:0] exp_data;
    bit            exp_err;
    logic [1:0]    exp_resp;
    int            exp_lat;
  } vec_t;

  function automatic logic [DW-1:0] word_of(input vec_t v, input int i);
    return (i == 0) ? v.op1 : (i == 1) ? v.op2 : v.opc;
  endfunction

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete(); aw1_log.delete(); ar1_log.delete();
    viol = 0; wr_cnt = 0;
  endtask

  // Counts edges from the accept edge until res_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!res_valid && lat < 300);
  endtask

  task automatic consume(input logic [CW-1:0] exp_done, input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_count"}, 32'(done_count), 32'(exp_done));
    chk({tag, "_res_valid_low"}, 32'(res_valid), 32'd0);
    chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int k, input logic [CW-1:0] exp_done);
    int lat, unstable, ready_seen;
    string tag;
    tag = $sformatf("v%0d", k);
    clear_logs();
    aw_delay = v.awd; w_delay = v.wd; berr_idx = v.berr_idx; berr_val = v.bv;
    rd_val = v.rd; rr_val = v.rr; r_stall = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op1 = v.op1; cmd_op2 = v.op2; cmd_opcode = v.opc;
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_result(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_res_data"}, 32'(res_data), 32'(v.exp_data));
    chk({tag, "_res_err"}, 32'(res_err), 32'(v.exp_err));
    chk({tag, "_res_resp"}, 32'(res_resp), 32'(v.exp_resp));
    unstable = 0; ready_seen = 0;
    for (int i = 0; i < v.hold; i++) begin
      if (v.pulse) cmd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== v.exp_data || res_err !== v.exp_err ||
          res_resp !== v.exp_resp) unstable++;
      if (cmd_ready !== 1'b0) ready_seen++;
    end
    cmd_valid = 1'b0;
    if (v.hold > 0) begin
      chk({tag, "_hold_stable"}, 32'(unstable), 32'd0);
      chk({tag, "_hold_cmd_ready"}, 32'(ready_seen), 32'd0);
    end
    consume(exp_done, tag);
    chk({tag, "_n_aw"}, 32'(aw_log.size()), 32'(v.exp_nwr));
    chk({tag, "_n_w"}, 32'(w_log.size()), 32'(v.exp_nwr));
    chk({tag, "_n_ar"}, 32'(ar_log.size()), 32'(v.exp_rd));
    for (int i = 0; i < v.exp_nwr && i < aw_log.size() && i < w_log.size(); i++) begin
      chk($sformatf("%s_awaddr%0d", tag, i), aw_log[i], 32'(i));
      chk($sformatf("%s_wdata%0d", tag, i), 32'(w_log[i]), 32'(word_of(v, i)));
    end
    if (v.exp_rd && ar_log.size() > 0) chk({tag, "_araddr"}, ar_log[0], 32'd3);
    chk({tag, "_protocol"}, 32'(viol), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int n_done;
    logic [AW-1:0] exp_aw_b[6];
    logic [DW-1:0] exp_w[6];
    // op1 op2 opc rd rr berr bv awd wd hold pulse | nwr rd data err resp lat
    vecs[0] = '{8'd2,   8'd3,   8'd0,   8'd5,   2'b00, -1, 2'b00, 0, 0, 0, 0, 3, 1, 8'd5,   0, 2'b00, 8};
    vecs[1] = '{8'd7,   8'd9,   8'd1,   8'h10,  2'b00, -1, 2'b00, 3, 0, 2, 0, 3, 1, 8'h10,  0, 2'b00, 17};
    vecs[2] = '{8'd7,   8'd9,   8'd1,   8'h10,  2'b00, -1, 2'b00, 0, 3, 0, 0, 3, 1, 8'h10,  0, 2'b00, 17};
    vecs[3] = '{8'd4,   8'd5,   8'd2,   8'h77,  2'b00,  1, 2'b10, 0, 0, 1, 0, 2, 0, 8'h00,  1, 2'b10, 4};
    vecs[4] = '{8'd1,   8'd1,   8'd3,   8'hA5,  2'b11, -1, 2'b00, 0, 0, 5, 1, 3, 1, 8'hA5,  1, 2'b11, 8};
    vecs[5] = '{8'h5A,  8'hC3,  8'd1,   8'h11,  2'b00,  0, 2'b01, 0, 0, 0, 0, 1, 0, 8'h00,  1, 2'b01, 2};
    vecs[6] = '{8'hFF,  8'h01,  8'd0,   8'h22,  2'b00,  2, 2'b11, 0, 0, 0, 0, 3, 0, 8'h00,  1, 2'b11, 6};
    vecs[7] = '{8'h80,  8'h7F,  8'hFF,  8'h7F,  2'b00, -1, 2'b00, 1, 2, 1, 0, 3, 1, 8'h7F,  0, 2'b00, 14};

    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_op1 = '0; cmd_op2 = '0; cmd_opcode = '0; res_ready = 1'b0;
    aw_delay = 0; w_delay = 0; berr_idx = -1; berr_val = 2'b00; rd_val = '0; rr_val = 2'b00;
    r_stall = 0; wr_cnt = 0; viol = 0;
    repeat (3) @(negedge clk);
    chk("rst_axi_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    chk("rst_addr_data", 32'(awaddr | araddr | 32'(wdata)), 32'd0);
    chk("rst_result", 32'({res_valid, res_err, res_resp, res_data}), 32'd0);
    chk("rst_done_count", 32'(done_count), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    #2 rstn = 1'b1;

    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      n_done++;
      run_vec(vecs[k], k, CW'(n_done));
    end
    chk("offset_dut_done", 32'(done_count_b), 32'(n_done));

    // back-to-back with cmd_valid held, on both base addresses
    clear_logs();
    aw_delay = 0; w_delay = 0; berr_idx = -1; rd_val = 8'h33; rr_val = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op1 = 8'h11; cmd_op2 = 8'h22; cmd_opcode = 8'h01;
    @(posedge clk); #1 cmd_op1 = 8'h44; cmd_op2 = 8'h55; cmd_opcode = 8'h02;
    wait_result(lat);
    chk("b2b_first_latency", 32'(lat), 32'd8);
    chk("b2b_first_data", 32'(res_data), 32'h33);
    rd_val = 8'h66;
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    n_done++;
    chk("b2b_first_done", 32'(done_count), 32'(n_done));
    chk("b2b_second_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_result(lat);
    chk("b2b_second_latency", 32'(lat), 32'd8);
    chk("b2b_second_data", 32'(res_data), 32'h66);
    n_done++;
    consume(CW'(n_done), "b2b_second");
    exp_aw_b = '{32'h40, 32'h41, 32'h42, 32'h40, 32'h41, 32'h42};
    exp_w    = '{8'h11, 8'h22, 8'h01, 8'h44, 8'h55, 8'h02};
    chk("b2b_n_aw_offset", 32'(aw1_log.size()), 32'd6);
    chk("b2b_n_ar_offset", 32'(ar1_log.size()), 32'd2);
    chk("b2b_n_w", 32'(w_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < aw1_log.size() && i < w_log.size(); i++) begin
      chk($sformatf("b2b_awaddr_offset%0d", i), aw1_log[i], exp_aw_b[i]);
      chk($sformatf("b2b_wdata%0d", i), 32'(w_log[i]), 32'(exp_w[i]));
    end
    for (int i = 0; i < ar1_log.size(); i++)
      chk($sformatf("b2b_araddr_offset%0d", i), ar1_log[i], 32'h43);

    // reset while waiting for read data
    clear_logs();
    r_stall = 1; rd_val = 8'h99;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op1 = 8'd6; cmd_op2 = 8'd7; cmd_opcode = 8'd0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0;
    while (!rready && lat < 50) begin @(negedge clk); lat++; end
    chk("rst_mid_reached_rd_data", 32'(rready), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_arvalid", 32'(arvalid), 32'd0);
    chk("rst_mid_rready", 32'(rready), 32'd0);
    chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_done_count", 32'(done_count), 32'd0);
    @(negedge clk); @(negedge clk);
    r_stall = 0;
    #2 rstn = 1'b1;
    chk("rst_mid_res_valid_after", 32'(res_valid), 32'd0);
    run_vec(vecs[0], 8, CW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
